// File: rtl/line_arb_pkg.sv
// Shared types for the cache-line request arbiter: FSM states, client ids, ops and the line container.
package line_arb_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS) + 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {CL_I, CL_D} client_t;
    typedef enum logic {RD, WR} op_t;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin picker; combinational winner, rr_last advances only when upd and a request is present.
// Latency 0 for the pick; no backpressure, the caller decides when a pick is consumed via upd.
module rr_arb2
    import line_arb_pkg::*;
(
    input  logic    aclk,
    input  logic    aresetn,
    input  logic    i_pend,
    input  logic    d_pend,
    input  logic    upd,
    output logic    any,
    output client_t win
);

    client_t rr_last;

    always_comb begin
        any = i_pend | d_pend;
        win = CL_I;
        if (i_pend && d_pend) begin
            win = (rr_last == CL_I) ? CL_D : CL_I;
        end else if (d_pend) begin
            win = CL_D;
        end
    end

    // Reset to CL_I so that the D-cache wins the first contested pick.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_last <= CL_I;
        end else if (upd && any) begin
            rr_last <= win;
        end
    end

endmodule

// File: rtl/line_req_arbiter.sv
// Arbitrates I-cache/D-cache line requests onto one line-burst adapter port and returns a grant pulse.
// Latency: mem req one cycle after the pick in IDLE; client gnt one cycle after mem_gnt. Clients wait on their level req.
module line_req_arbiter
    import line_arb_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        i_rd_req,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    output logic                        i_gnt,
    output logic [LINE_WORDS-1:0][31:0] i_rd_line,
    input  logic                        d_rd_req,
    input  logic                        d_wr_req,
    input  logic [ADDR_WIDTH-1:0]       d_addr,
    input  logic [LINE_WORDS-1:0][31:0] d_wr_line,
    output logic                        d_gnt,
    output logic [LINE_WORDS-1:0][31:0] d_rd_line,
    output logic                        mem_rd_req,
    output logic                        mem_wr_req,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [LINE_WORDS-1:0][31:0] mem_wr_line,
    input  logic [LINE_WORDS-1:0][31:0] mem_rd_line,
    input  logic                        mem_gnt
);

    localparam int OFF = $clog2(LINE_WORDS) + 2;

    state_t  state;
    client_t cl;
    op_t     op;
    logic    pend_any;
    client_t win;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    endfunction

    rr_arb2 u_rr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_pend  (i_rd_req),
        .d_pend  (d_rd_req | d_wr_req),
        .upd     (state == IDLE),
        .any     (pend_any),
        .win     (win)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            cl          <= CL_I;
            op          <= RD;
            i_gnt       <= 1'b0;
            d_gnt       <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_line <= '0;
            i_rd_line   <= '0;
            d_rd_line   <= '0;
        end else begin
            i_gnt <= 1'b0;
            d_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_any) begin
                        cl    <= win;
                        state <= BUSY;
                        if (win == CL_D) begin
                            mem_addr <= line_base(d_addr);
                            // A write-back takes precedence when the D side raises both.
                            if (d_wr_req) begin
                                op          <= WR;
                                mem_wr_req  <= 1'b1;
                                mem_wr_line <= d_wr_line;
                            end else begin
                                op         <= RD;
                                mem_rd_req <= 1'b1;
                            end
                        end else begin
                            op         <= RD;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= line_base(i_addr);
                        end
                    end
                end
                BUSY: begin
                    if (mem_gnt) begin
                        mem_rd_req <= 1'b0;
                        mem_wr_req <= 1'b0;
                        if (op == RD) begin
                            if (cl == CL_I) begin
                                i_rd_line <= mem_rd_line;
                            end else begin
                                d_rd_line <= mem_rd_line;
                            end
                        end
                        i_gnt <= (cl == CL_I);
                        d_gnt <= (cl == CL_D);
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_req_arbiter.sv
// Bench for line_req_arbiter: directed scenarios plus randomized traffic against a behavioural arbitration model.
module tb_line_req_arbiter;
    import line_arb_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        i_rd_req, d_rd_req, d_wr_req, mem_gnt;
    logic [31:0] i_addr, d_addr;
    line_t       d_wr_line, mem_rd_line;
    logic        i_gnt, d_gnt, mem_rd_req, mem_wr_req;
    line_t       i_rd_line, d_rd_line, mem_wr_line;
    logic [31:0] mem_addr;

    int    checks = 0;
    int    errors = 0;
    int    last_d;
    line_t exp_i_line, exp_d_line, exp_wline;

    always #5 aclk = ~aclk;

    line_req_arbiter #(.LINE_WORDS(8), .ADDR_WIDTH(32)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_rd_req    (i_rd_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_rd_line   (i_rd_line),
        .d_rd_req    (d_rd_req),
        .d_wr_req    (d_wr_req),
        .d_addr      (d_addr),
        .d_wr_line   (d_wr_line),
        .d_gnt       (d_gnt),
        .d_rd_line   (d_rd_line),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt)
    );

    function automatic logic [31:0] base(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int k = 0; k < 8; k++) r[k] = $urandom;
        return r;
    endfunction

    // Both pending: the client that did not win last time; otherwise the only one pending.
    function automatic int pick(input bit ip, input bit dp);
        if (ip && dp) return (last_d != 0) ? 0 : 1;
        return dp ? 1 : 0;
    endfunction

    task automatic model_reset();
        last_d     = 0;
        exp_i_line = '0;
        exp_d_line = '0;
        exp_wline  = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        i_rd_req = 0; d_rd_req = 0; d_wr_req = 0; mem_gnt = 0;
        i_addr = 0; d_addr = 0; d_wr_line = '0; mem_rd_line = '0;
        @(negedge aclk);
        @(negedge aclk);
        model_reset();
        aresetn = 1'b1;
    endtask

    // Plays the adapter for one transaction and checks the arbiter against the model.
    task automatic serve(input int cl, input bit wr, input logic [31:0] addr, input line_t wline,
                         input int exp_wait, input int beats, input line_t rl, input string nm);
        int w;
        bit seen;
        w = 0;
        seen = 0;
        for (int k = 1; k <= 6 && !seen; k++) begin
            @(negedge aclk);
            if (mem_rd_req || mem_wr_req) begin
                seen = 1;
                w = k;
            end else begin
                checks++;
                if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_gnt: i_gnt=%b d_gnt=%b, want 0 0", nm, i_gnt, d_gnt);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s req_timeout: no mem req within 6 cycles", nm);
            return;
        end
        if (w != exp_wait) begin
            errors++;
            $display("FAIL %s req_latency: got %0d cycles, want %0d", nm, w, exp_wait);
        end
        if (wr) exp_wline = wline;
        last_d = cl;
        for (int b = 0; b < beats; b++) begin
            if (b > 0) @(negedge aclk);
            checks++;
            if (mem_rd_req !== (wr ? 1'b0 : 1'b1) || mem_wr_req !== wr || mem_addr !== base(addr)
                || mem_wr_line !== exp_wline || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL %s busy beat %0d: rd=%b wr=%b addr=%h gnt=%b%b, want rd=%b wr=%b addr=%h gnt=00 wline_ok=%b",
                         nm, b, mem_rd_req, mem_wr_req, mem_addr, i_gnt, d_gnt, !wr, wr, base(addr),
                         mem_wr_line === exp_wline);
            end
        end
        mem_gnt = 1'b1;
        mem_rd_line = rl;
        @(negedge aclk);
        mem_gnt = 1'b0;
        mem_rd_line = rand_line();
        if (!wr) begin
            if (cl == 0) exp_i_line = rl;
            else exp_d_line = rl;
        end
        checks++;
        if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_memreq: rd=%b wr=%b, want 0 0", nm, mem_rd_req, mem_wr_req);
        end
        checks++;
        if (i_gnt !== (cl == 0) || d_gnt !== (cl == 1)) begin
            errors++;
            $display("FAIL %s resp_gnt: i_gnt=%b d_gnt=%b, want %b %b", nm, i_gnt, d_gnt, cl == 0, cl == 1);
        end
        checks++;
        if (i_rd_line !== exp_i_line || d_rd_line !== exp_d_line) begin
            errors++;
            $display("FAIL %s resp_lines: i=%h d=%h, want i=%h d=%h", nm, i_rd_line, d_rd_line, exp_i_line, exp_d_line);
        end
        if (cl == 0) i_rd_req = 1'b0;
        else begin
            d_rd_req = 1'b0;
            d_wr_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        i_rd_req = 0; d_rd_req = 0; d_wr_req = 0; mem_gnt = 0;
        i_addr = 0; d_addr = 0; d_wr_line = '0; mem_rd_line = '0;
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if (i_gnt !== 0 || d_gnt !== 0 || mem_rd_req !== 0 || mem_wr_req !== 0 || mem_addr !== 0
            || mem_wr_line !== '0 || i_rd_line !== '0 || d_rd_line !== '0) begin
            errors++;
            $display("FAIL reset_values: gnt=%b%b req=%b%b addr=%h, want all zero", i_gnt, d_gnt,
                     mem_rd_req, mem_wr_req, mem_addr);
        end
        model_reset();
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_i_read();
        line_t rl;
        for (int k = 0; k < 8; k++) rl[k] = 32'hA0 + k;
        i_addr = 32'h1FC0_0014;
        i_rd_req = 1'b1;
        serve(0, 1'b0, i_addr, '0, 1, 8, rl, "i_read");
        checks++;
        if (i_rd_line[3] !== 32'hA3) begin
            errors++;
            $display("FAIL i_read word3: got %h, want 000000a3", i_rd_line[3]);
        end
        @(negedge aclk);
    endtask

    task automatic test_d_writeback();
        for (int k = 0; k < 8; k++) d_wr_line[k] = 32'h10 + k;
        d_addr = 32'h0000_103C;
        d_wr_req = 1'b1;
        serve(1, 1'b1, d_addr, d_wr_line, 1, 8, rand_line(), "d_writeback");
        checks++;
        if (exp_wline[7] !== 32'h17 || mem_wr_line !== exp_wline) begin
            errors++;
            $display("FAIL d_writeback hold: mem_wr_line[7]=%h, want 00000017", mem_wr_line[7]);
        end
        @(negedge aclk);
    endtask

    task automatic test_back_to_back();
        int cl;
        int order[4];
        do_reset();
        i_addr = $urandom; d_addr = $urandom;
        i_rd_req = 1'b1; d_rd_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cl = pick(1, 1);
            order[n] = cl;
            serve(cl, 1'b0, (cl == 0) ? i_addr : d_addr, '0, (n == 0) ? 1 : 2, 8, rand_line(), "back_to_back");
            if (cl == 0) begin i_addr = $urandom; i_rd_req = 1'b1; end
            else begin d_addr = $urandom; d_rd_req = 1'b1; end
        end
        checks++;
        if (order[0] != 1 || order[1] != 0 || order[2] != 1 || order[3] != 0) begin
            errors++;
            $display("FAIL back_to_back order: got %0d%0d%0d%0d, want 1010 (D,I,D,I)", order[0], order[1], order[2], order[3]);
        end
        i_rd_req = 1'b0; d_rd_req = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
    endtask

    task automatic test_wb_refill();
        d_addr = 32'h0000_4468;
        d_wr_line = rand_line();
        d_wr_req = 1'b1;
        serve(1, 1'b1, d_addr, d_wr_line, 1, 8, rand_line(), "wb_then_refill_wb");
        d_rd_req = 1'b1;
        serve(1, 1'b0, d_addr, '0, 2, 8, rand_line(), "wb_then_refill_rd");
        @(negedge aclk);
    endtask

    task automatic test_both_d();
        d_addr = $urandom;
        d_wr_line = rand_line();
        d_rd_req = 1'b1;
        d_wr_req = 1'b1;
        serve(1, 1'b1, d_addr, d_wr_line, 1, 5, rand_line(), "d_rd_and_wr");
        @(negedge aclk);
    endtask

    task automatic test_gnt_ignored();
        mem_gnt = 1'b1;
        @(negedge aclk);
        mem_gnt = 1'b0;
        @(negedge aclk);
        checks++;
        if (i_gnt !== 0 || d_gnt !== 0 || mem_rd_req !== 0 || mem_wr_req !== 0) begin
            errors++;
            $display("FAIL stray_mem_gnt: gnt=%b%b req=%b%b, want 0000", i_gnt, d_gnt, mem_rd_req, mem_wr_req);
        end
    endtask

    task automatic test_reset_busy();
        d_addr = $urandom;
        d_wr_line = rand_line();
        d_wr_req = 1'b1;
        @(negedge aclk);
        checks++;
        if (mem_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy start: mem_wr_req=%b, want 1", mem_wr_req);
        end
        for (int k = 0; k < 3; k++) @(negedge aclk);
        aresetn = 1'b0;
        d_wr_req = 1'b0;
        @(negedge aclk);
        checks++;
        if (i_gnt !== 0 || d_gnt !== 0 || mem_rd_req !== 0 || mem_wr_req !== 0 || mem_addr !== 0
            || mem_wr_line !== '0 || i_rd_line !== '0 || d_rd_line !== '0) begin
            errors++;
            $display("FAIL reset_busy values: gnt=%b%b req=%b%b addr=%h, want all zero", i_gnt, d_gnt,
                     mem_rd_req, mem_wr_req, mem_addr);
        end
        model_reset();
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (i_gnt !== 0 || d_gnt !== 0 || mem_rd_req !== 0 || mem_wr_req !== 0) begin
            errors++;
            $display("FAIL reset_busy after: gnt=%b%b req=%b%b, want 0000", i_gnt, d_gnt, mem_rd_req, mem_wr_req);
        end
        i_addr = $urandom;
        i_rd_req = 1'b1;
        serve(0, 1'b0, i_addr, '0, 1, 8, rand_line(), "reset_busy_then_i");
        @(negedge aclk);
    endtask

    task automatic test_random();
        bit ip, dp, wr;
        int cl;
        int w;
        ip = 0; dp = 0; w = 1;
        for (int n = 0; n < 40; n++) begin
            if (!ip && ($urandom_range(0, 1) == 1)) begin
                ip = 1; i_addr = $urandom; i_rd_req = 1'b1;
            end
            if (!dp && ($urandom_range(0, 1) == 1)) begin
                dp = 1; d_addr = $urandom; d_wr_line = rand_line();
                case ($urandom_range(0, 2))
                    0: begin d_rd_req = 1'b1; d_wr_req = 1'b0; end
                    1: begin d_rd_req = 1'b0; d_wr_req = 1'b1; end
                    default: begin d_rd_req = 1'b1; d_wr_req = 1'b1; end
                endcase
            end
            if (!ip && !dp) begin
                ip = 1; i_addr = $urandom; i_rd_req = 1'b1;
            end
            cl = pick(ip, dp);
            wr = (cl == 1) && d_wr_req;
            serve(cl, wr, (cl == 0) ? i_addr : d_addr, d_wr_line, w, $urandom_range(1, 12), rand_line(), "random");
            if (cl == 0) ip = 0;
            else dp = 0;
            w = 2;
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_writeback();
        test_back_to_back();
        test_wb_refill();
        test_both_d();
        test_gnt_ignored();
        test_reset_busy();
        do_reset();
        @(negedge aclk);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
